tmr_run_controller: RTL and testbench

//  Sequencer and fault manager for the triplicated 16-bit counter (three lanes + majority voter).

---
 rtl/tmr_pkg.sv | 18 +
 rtl/tmr_lane_monitor.sv | 36 +++
 rtl/tmr_run_controller.sv | 108 ++++++++++
 tb/tb_tmr_run_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared types and helpers for the triplicated-counter run controller.
package tmr_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned ERR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ALARM = 2'd3
    } state_t;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/tmr_lane_monitor.sv
// Per-lane fault history: saturating mismatch counter plus sticky failed flag.
module tmr_lane_monitor #(
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned FAIL_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             count_en,
    input  logic             fault_i,
    input  logic             clear,
    output logic [ERR_W-1:0] err_cnt,
    output logic             failed
);

    logic [ERR_W-1:0] cnt_inc;

    always_comb begin
        cnt_inc = (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
            failed  <= 1'b0;
        end else if (clear) begin
            err_cnt <= '0;
            failed  <= 1'b0;
        end else if (count_en && fault_i) begin
            err_cnt <= cnt_inc;
            // flag rises on the same edge the counter reaches the threshold
            if (cnt_inc >= ERR_W'(FAIL_THRESH))
                failed <= 1'b1;
        end
    end

endmodule

// File: rtl/tmr_run_controller.sv
// Run sequencer and fault manager for a three-lane counter with majority voter.
module tmr_run_controller
    import tmr_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter int unsigned ERR_W       = ERR_W_DEF,
    parameter int unsigned FAIL_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] voted_q,
    input  logic [2:0]       fault,
    output logic             cnt_enable,
    output logic             busy,
    output logic             done,
    output logic             alarm,
    output logic [2:0]       lane_failed,
    output logic [ERR_W-1:0] err_cnt_1,
    output logic [ERR_W-1:0] err_cnt_2,
    output logic [ERR_W-1:0] err_cnt_3
);

    state_t           state, state_nx;
    logic [WIDTH-1:0] target_q;
    logic             load_target;
    logic             in_run;
    logic             clear_ok;
    logic             alarm_cond;
    logic [ERR_W-1:0] err_cnt [3];

    assign in_run   = (state == RUN);
    assign clear_ok = clear && ((state == IDLE) || (state == ALARM));

    for (genvar i = 0; i < 3; i++) begin : g_lane
        tmr_lane_monitor #(
            .ERR_W      (ERR_W),
            .FAIL_THRESH(FAIL_THRESH)
        ) u_mon (
            .clk     (clk),
            .rst     (rst),
            .count_en(in_run),
            .fault_i (fault[i]),
            .clear   (clear_ok),
            .err_cnt (err_cnt[i]),
            .failed  (lane_failed[i])
        );
    end

    assign err_cnt_1 = err_cnt[0];
    assign err_cnt_2 = err_cnt[1];
    assign err_cnt_3 = err_cnt[2];

    assign alarm_cond = (popcount3(fault) >= 2'd2) || (popcount3(lane_failed) >= 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            target_q <= '0;
        end else begin
            state <= state_nx;
            if (load_target)
                target_q <= target;
        end
    end

    // outputs decode from the registered state so reset clears them asynchronously
    always_comb begin
        state_nx    = state;
        load_target = 1'b0;
        cnt_enable  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        alarm       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    load_target = 1'b1;
                    state_nx    = RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                cnt_enable = (voted_q != target_q);
                if (alarm_cond)
                    state_nx = ALARM;
                else if (stop)
                    state_nx = IDLE;
                else if (voted_q == target_q)
                    state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            ALARM: begin
                alarm = 1'b1;
                if (clear)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tmr_run_controller.sv
// Directed bench: real three-lane counter and voter around the controller, faults injected per lane.
module tb_tmr_run_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [15:0] target = '0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic        f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;

    logic [15:0] q1, q2, q3, q1e, q2e, q3e, voted;
    logic [2:0]  fault;
    logic        cnt_enable, busy, done, alarm;
    logic [2:0]  lane_failed;
    logic [7:0]  err_cnt_1, err_cnt_2, err_cnt_3;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1 <= '0; q2 <= '0; q3 <= '0;
        end else if (load) begin
            q1 <= load_val; q2 <= load_val; q3 <= load_val;
        end else if (cnt_enable) begin
            q1 <= q1 + 16'd1; q2 <= q2 + 16'd1; q3 <= q3 + 16'd1;
        end
    end

    assign q1e   = f1 ? (q1 ^ 16'h0F00) : q1;
    assign q2e   = f2 ? (q2 ^ 16'h00FF) : q2;
    assign q3e   = f3 ? (q3 ^ 16'hF000) : q3;
    assign voted = (q1e & q2e) | (q1e & q3e) | (q2e & q3e);
    assign fault = {q3e != voted, q2e != voted, q1e != voted};

    tmr_run_controller #(
        .WIDTH      (16),
        .ERR_W      (8),
        .FAIL_THRESH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .target     (target),
        .voted_q    (voted),
        .fault      (fault),
        .cnt_enable (cnt_enable),
        .busy       (busy),
        .done       (done),
        .alarm      (alarm),
        .lane_failed(lane_failed),
        .err_cnt_1  (err_cnt_1),
        .err_cnt_2  (err_cnt_2),
        .err_cnt_3  (err_cnt_3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_lanes(input logic [15:0] v);
        load_val = v; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic start_run(input logic [15:0] t);
        target = t; start = 1'b1;
        tick();
        start = 1'b0;
        target = 16'h5A5A;  // later target changes must not matter
    endtask

    // runs a bounded number of cycles, tallying enable cycles and done pulses
    task automatic run_cycles(input int n, output int en_cycles, output int dones);
        en_cycles = 0; dones = 0;
        for (int i = 0; i < n; i++) begin
            if (cnt_enable) en_cycles++;
            if (done) dones++;
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_cmp++; if ({cnt_enable, busy, done, alarm} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl got=%b exp=0000", {cnt_enable, busy, done, alarm}); end
        n_cmp++; if ({lane_failed, err_cnt_1, err_cnt_2, err_cnt_3} !== 27'd0) begin n_fail++; $display("FAIL reset_faults got=%h exp=0", {lane_failed, err_cnt_1, err_cnt_2, err_cnt_3}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_run();
        int en, dn;
        start_run(16'd10);
        n_cmp++; if ({busy, cnt_enable} !== 2'b11) begin n_fail++; $display("FAIL basic_first_cycle got=%b exp=11", {busy, cnt_enable}); end
        run_cycles(30, en, dn);
        n_cmp++; if (en !== 10) begin n_fail++; $display("FAIL basic_en_cycles got=%0d exp=10", en); end
        n_cmp++; if (dn !== 1) begin n_fail++; $display("FAIL basic_done_pulses got=%0d exp=1", dn); end
        n_cmp++; if (voted !== 16'd10) begin n_fail++; $display("FAIL basic_final got=%0d exp=10", voted); end
        n_cmp++; if ({busy, cnt_enable} !== 2'b00) begin n_fail++; $display("FAIL basic_idle got=%b exp=00", {busy, cnt_enable}); end
    endtask

    task automatic test_wrap();
        int en, dn;
        load_lanes(16'hFFFE);
        start_run(16'h0002);
        run_cycles(20, en, dn);
        n_cmp++; if (en !== 4) begin n_fail++; $display("FAIL wrap_en_cycles got=%0d exp=4", en); end
        n_cmp++; if (dn !== 1) begin n_fail++; $display("FAIL wrap_done got=%0d exp=1", dn); end
        n_cmp++; if (voted !== 16'h0002) begin n_fail++; $display("FAIL wrap_final got=%h exp=0002", voted); end
    endtask

    task automatic test_equal_target();
        start_run(16'h0002);
        n_cmp++; if ({busy, cnt_enable, done} !== 3'b100) begin n_fail++; $display("FAIL eq_run got=%b exp=100", {busy, cnt_enable, done}); end
        tick();
        n_cmp++; if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL eq_done got=%b exp=01", {busy, done}); end
        tick();
        n_cmp++; if ({busy, done, voted} !== {2'b00, 16'h0002}) begin n_fail++; $display("FAIL eq_after got=%h exp=0002", {busy, done, voted}); end
    endtask

    task automatic test_lane_fail();
        int en, dn;
        load_lanes(16'd0);
        start_run(16'd40);
        for (int k = 0; k < 4; k++) begin
            f2 = 1'b1; tick();
            f2 = 1'b0; tick();
        end
        run_cycles(60, en, dn);
        n_cmp++; if (err_cnt_2 !== 8'd4) begin n_fail++; $display("FAIL lf_err2 got=%0d exp=4", err_cnt_2); end
        n_cmp++; if ({err_cnt_1, err_cnt_3} !== 16'd0) begin n_fail++; $display("FAIL lf_err13 got=%h exp=0", {err_cnt_1, err_cnt_3}); end
        n_cmp++; if (lane_failed !== 3'b010) begin n_fail++; $display("FAIL lf_flags got=%b exp=010", lane_failed); end
        n_cmp++; if (dn !== 1 || voted !== 16'd40) begin n_fail++; $display("FAIL lf_complete got done=%0d voted=%0d exp done=1 voted=40", dn, voted); end
    endtask

    task automatic test_alarm();
        logic [15:0] held;
        load_lanes(16'd0);
        start_run(16'd30);
        tick();
        f1 = 1'b1; f3 = 1'b1; tick();
        f1 = 1'b0; f3 = 1'b0;
        n_cmp++; if ({alarm, cnt_enable, busy} !== 3'b100) begin n_fail++; $display("FAIL alarm_enter got=%b exp=100", {alarm, cnt_enable, busy}); end
        n_cmp++; if ({err_cnt_1, err_cnt_3} !== {8'd1, 8'd1}) begin n_fail++; $display("FAIL alarm_err13 got=%h exp=0101", {err_cnt_1, err_cnt_3}); end
        held = voted;
        target = 16'd100; start = 1'b1; stop = 1'b1;
        repeat (3) tick();
        start = 1'b0; stop = 1'b0;
        n_cmp++; if ({alarm, busy, voted} !== {2'b10, held}) begin n_fail++; $display("FAIL alarm_hold got=%h exp=%h", {alarm, busy, voted}, {2'b10, held}); end
        clear = 1'b1; tick(); clear = 1'b0;
        n_cmp++; if ({alarm, busy, lane_failed} !== 5'b0) begin n_fail++; $display("FAIL alarm_clear_flags got=%b exp=00000", {alarm, busy, lane_failed}); end
        n_cmp++; if ({err_cnt_1, err_cnt_2, err_cnt_3} !== 24'd0) begin n_fail++; $display("FAIL alarm_clear_cnts got=%h exp=0", {err_cnt_1, err_cnt_2, err_cnt_3}); end
    endtask

    task automatic test_stop();
        int en, dn, w;
        load_lanes(16'd0);
        start_run(16'd20);
        w = 0;
        while (voted != 16'd5 && w < 40) begin tick(); w++; end
        n_cmp++; if (voted !== 16'd5) begin n_fail++; $display("FAIL stop_reach got=%0d exp=5", voted); end
        stop = 1'b1; tick(); stop = 1'b0;
        n_cmp++; if ({busy, cnt_enable, done} !== 3'b000) begin n_fail++; $display("FAIL stop_idle got=%b exp=000", {busy, cnt_enable, done}); end
        run_cycles(10, en, dn);
        n_cmp++; if (dn !== 0 || en !== 0 || voted > 16'd6) begin n_fail++; $display("FAIL stop_hold got done=%0d en=%0d voted=%0d exp 0 0 <=6", dn, en, voted); end
        target = 16'd30; start = 1'b1; stop = 1'b1; tick();
        start = 1'b0; stop = 1'b0;
        n_cmp++; if ({busy, cnt_enable} !== 2'b00) begin n_fail++; $display("FAIL start_stop got=%b exp=00", {busy, cnt_enable}); end
    endtask

    task automatic test_reset_midrun_and_saturation();
        int en, dn, w;
        load_lanes(16'd0);
        start_run(16'd100);
        w = 0;
        while (voted != 16'd7 && w < 40) begin tick(); w++; end
        n_cmp++; if ({voted, cnt_enable} !== {16'd7, 1'b1}) begin n_fail++; $display("FAIL rst_reach got=%h exp=0007/1", {voted, cnt_enable}); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({cnt_enable, busy, done, alarm, lane_failed} !== 7'd0 || voted !== 16'd0) begin n_fail++; $display("FAIL rst_async got=%b voted=%0d exp=0", {cnt_enable, busy, done, alarm, lane_failed}, voted); end
        tick();
        rst = 1'b0;
        tick();
        start_run(16'd1000);
        f1 = 1'b1;
        repeat (300) tick();
        n_cmp++; if (err_cnt_1 !== 8'd255) begin n_fail++; $display("FAIL sat_err1 got=%0d exp=255", err_cnt_1); end
        n_cmp++; if ({lane_failed, alarm, busy} !== 5'b00101) begin n_fail++; $display("FAIL sat_flags got=%b exp=00101", {lane_failed, alarm, busy}); end
        f1 = 1'b0;
        run_cycles(1100, en, dn);
        n_cmp++; if (dn !== 1 || voted !== 16'd1000) begin n_fail++; $display("FAIL sat_complete got done=%0d voted=%0d exp 1 1000", dn, voted); end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_wrap();
        test_equal_target();
        test_lane_fail();
        test_alarm();
        test_stop();
        test_reset_midrun_and_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
